// File: rtl/unified_memory_mp.sv
// Unified instruction/data/node memory with hardware zero-fill sweep.
// Registered instruction and data ports plus a lane-gathering node burst port.
module unified_memory_mp #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 11,
    parameter int NODE_LANES = 16
) (
    input  logic                         iclk,
    input  logic                         irst_n,
    input  logic                         iClear,
    output logic                         oClearBusy,
    input  logic [ADDR_W-1:0]            iInstrAddr,
    output logic [DATA_W-1:0]            oInstr,
    input  logic [ADDR_W-1:0]            iDataAddr,
    input  logic                         iDataWrite,
    input  logic [DATA_W-1:0]            iData,
    output logic [DATA_W-1:0]            oData,
    input  logic                         iNodeReq,
    input  logic [ADDR_W-1:0]            iNodeAddr,
    output logic                         oNodeBusy,
    output logic                         oNodeValid,
    input  logic                         iNodeAck,
    output logic [NODE_LANES*DATA_W-1:0] oNodes
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (NODE_LANES > 1) ? $clog2(NODE_LANES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NODE_LANES - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] clearPtr;
    logic              clearBusy;
    logic              clearStart;

    logic [1:0]        state;
    logic [ADDR_W-1:0] nodeBase;
    logic [CNT_W-1:0]  nodeCnt;
    logic [ADDR_W-1:0] fetchAddr;

    assign fetchAddr  = nodeBase + ADDR_W'(nodeCnt);
    assign clearStart = iClear & ~clearBusy & (state == ST_IDLE);

    assign oClearBusy = clearBusy;
    assign oNodeBusy  = (state != ST_IDLE) | clearBusy;

    // Storage has no reset; the sweep owns the write port while it runs.
    always_ff @(posedge iclk) begin
        if (clearBusy) begin
            mem[clearPtr] <= '0;
        end else if (iDataWrite) begin
            mem[iDataAddr] <= iData;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            clearBusy <= 1'b1;
            clearPtr  <= '0;
        end else if (clearBusy) begin
            clearPtr <= clearPtr + 1'b1;
            if (clearPtr == PTR_LAST) begin
                clearBusy <= 1'b0;
            end
        end else if (clearStart) begin
            clearBusy <= 1'b1;
            clearPtr  <= '0;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            oInstr <= '0;
            oData  <= '0;
        end else if (clearBusy) begin
            oInstr <= '0;
            oData  <= '0;
        end else begin
            oInstr <= mem[iInstrAddr];
            oData  <= mem[iDataAddr];
        end
    end

    // Lane k is captured on the (k+1)-th edge after the accepting edge.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state      <= ST_IDLE;
            nodeBase   <= '0;
            nodeCnt    <= '0;
            oNodes     <= '0;
            oNodeValid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iNodeReq && !clearBusy) begin
                        nodeBase <= iNodeAddr;
                        nodeCnt  <= '0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    oNodes[nodeCnt*DATA_W +: DATA_W] <= mem[fetchAddr];
                    if (nodeCnt == CNT_LAST) begin
                        state      <= ST_HOLD;
                        oNodeValid <= 1'b1;
                    end else begin
                        nodeCnt <= nodeCnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (iNodeAck) begin
                        state      <= ST_IDLE;
                        oNodeValid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    oNodeValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
